// File: rtl/ip_seq_ctrl.sv
// Instruction-pointer sequencing control: picks the next-IP source each cycle, owns the IP
// register, a return-address stack and the single-level interrupt entry/exit handshake.
module ip_seq_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          DEPTH     = 8,
  parameter int          PTR_W     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  input  logic             br_taken,
  input  logic             call,
  input  logic             ret,
  input  logic [31:0]      br_target,
  input  logic             irq,
  input  logic             int_en,
  input  logic [31:0]      int_vec,
  output logic [2:0]       IP_sel,
  output logic [31:0]      ip,
  output logic             int_ack,
  output logic             in_isr,
  output logic             stack_err,
  output logic [PTR_W:0]   sp
);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  localparam logic [2:0] SEL_SEQ  = 3'b000;
  localparam logic [2:0] SEL_TGT  = 3'b001;
  localparam logic [2:0] SEL_STK  = 3'b010;
  localparam logic [2:0] SEL_INT  = 3'b011;
  localparam logic [2:0] SEL_RST  = 3'b100;
  localparam logic [2:0] SEL_HOLD = 3'b111;

  localparam logic [PTR_W:0] SP_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] SP_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [31:0]    IP_STEP = 32'd4;

  state_t           r_state;
  state_t           w_state_next;
  logic [31:0]      r_ip;
  logic [31:0]      w_ip_next;
  logic [31:0]      w_ip_seq;
  logic [PTR_W:0]   r_sp;
  logic [PTR_W:0]   w_sp_next;
  logic             r_in_isr;
  logic             r_stack_err;
  logic [31:0]      r_stack [DEPTH];

  logic [2:0]       w_ip_sel;
  logic             w_int_ack;
  logic             w_push_req;
  logic             w_pop;
  logic [31:0]      w_push_data;
  logic             w_set_isr;
  logic             w_clr_isr;
  logic             w_set_err;
  logic             w_full;
  logic             w_empty;
  logic             w_push_ok;
  logic [PTR_W-1:0] w_top_idx;
  logic [PTR_W-1:0] w_wr_idx;

  assign w_full    = (r_sp == SP_FULL);
  assign w_empty   = (r_sp == '0);
  assign w_ip_seq  = r_ip + IP_STEP;
  assign w_top_idx = PTR_W'(r_sp - SP_ONE);
  assign w_wr_idx  = r_sp[PTR_W-1:0];
  assign w_push_ok = w_push_req & ~w_full;

  // Request arbitration: one source per advancing cycle, lower-priority requests are dropped.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_state_next = r_state;
    w_ip_sel     = SEL_HOLD;
    w_int_ack    = 1'b0;
    w_push_req   = 1'b0;
    w_push_data  = r_ip;
    w_pop        = 1'b0;
    w_set_isr    = 1'b0;
    w_clr_isr    = 1'b0;
    w_set_err    = 1'b0;
    unique case (r_state)
      ST_INIT: begin
        w_ip_sel     = SEL_RST;
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (adv) begin
          if (irq && int_en && !r_in_isr) begin
            w_ip_sel    = SEL_INT;
            w_int_ack   = 1'b1;
            w_push_req  = 1'b1;
            w_push_data = r_ip;
            w_set_isr   = 1'b1;
            w_set_err   = w_full;
          end else if (ret) begin
            if (!w_empty) begin
              w_ip_sel  = SEL_STK;
              w_pop     = 1'b1;
              w_clr_isr = 1'b1;
            end else begin
              w_ip_sel  = SEL_SEQ;
              w_set_err = 1'b1;
            end
          end else if (call) begin
            w_ip_sel    = SEL_TGT;
            w_push_req  = 1'b1;
            w_push_data = w_ip_seq;
            w_set_err   = w_full;
          end else if (br_taken) begin
            w_ip_sel = SEL_TGT;
          end else begin
            w_ip_sel = SEL_SEQ;
          end
        end
      end
      default: begin
        w_ip_sel     = SEL_RST;
        w_state_next = ST_INIT;
      end
    endcase
  end

  always_comb begin
    w_ip_next = r_ip;
    unique case (w_ip_sel)
      SEL_SEQ: w_ip_next = w_ip_seq;
      SEL_TGT: w_ip_next = br_target;
      SEL_STK: w_ip_next = r_stack[w_top_idx];
      SEL_INT: w_ip_next = int_vec;
      SEL_RST: w_ip_next = RESET_VEC;
      default: w_ip_next = r_ip;
    endcase
  end

  always_comb begin
    w_sp_next = r_sp;
    if (w_push_ok) begin
      w_sp_next = r_sp + SP_ONE;
    end else if (w_pop) begin
      w_sp_next = r_sp - SP_ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_ip        <= RESET_VEC;
      r_sp        <= '0;
      r_in_isr    <= 1'b0;
      r_stack_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ip    <= w_ip_next;
      r_sp    <= w_sp_next;
      if (w_set_isr) begin
        r_in_isr <= 1'b1;
      end else if (w_clr_isr) begin
        r_in_isr <= 1'b0;
      end
      if (w_set_err) begin
        r_stack_err <= 1'b1;
      end
    end
  end

  // NOTE: stack storage has no reset; entries above sp are never read, so contents are don't-care.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_stack[w_wr_idx] <= w_push_data;
    end
  end

  assign IP_sel    = w_ip_sel;
  assign ip        = r_ip;
  assign int_ack   = w_int_ack;
  assign in_isr    = r_in_isr;
  assign stack_err = r_stack_err;
  assign sp        = r_sp;

endmodule

// File: doc/ip_seq_ctrl.md
Name: ip_seq_ctrl

Overview:
- Control end of the instruction-pointer select path: decides each cycle which next-IP source is taken and drives the 3-bit select code consumed by the IP selection mux.
- Owns the architectural IP register, an 8-deep return-address stack (call/return) and the interrupt entry/exit handshake.
- Sits between the decode/branch unit and the fetch stage.

Parameters:
- RESET_VEC, 32'h0000_0000, IP loaded on reset and in INIT.
- DEPTH, 8, return-stack entries (power of 2, 2..16).
- PTR_W, 3, log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- adv  in  1  advance enable; IP updates only when 1.
- br_taken  in  1  taken branch this cycle.
- call  in  1  call; qualifies br_target as destination, pushes return address.
- ret  in  1  return; pops stack.
- br_target  in  32  branch/call destination.
- irq  in  1  level interrupt request.
- int_en  in  1  global interrupt enable.
- int_vec  in  32  interrupt handler address.
- IP_sel  out  3  select code: 000 seq (ip+4), 001 branch/call target, 010 stack top, 011 int_vec, 100 RESET_VEC, 111 hold.
- ip  out  32  current instruction pointer (registered).
- int_ack  out  1  one-cycle pulse on interrupt entry.
- in_isr  out  1  handler active.
- stack_err  out  1  sticky over/underflow flag.
- sp  out  PTR_W+1  stack occupancy 0..DEPTH.

Behaviour:
- Reset (async): ip=RESET_VEC, IP_sel=100, state=INIT, sp=0, int_ack=0, in_isr=0, stack_err=0.
- IP_sel is combinational from state and inputs; ip, sp, flags and the stack update on the rising clk edge.
- State INIT: IP_sel=100; ip<=RESET_VEC; go to RUN next cycle regardless of adv; all other inputs ignored.
- State RUN, adv=0: IP_sel=111; all state held; int_ack=0.
- State RUN, adv=1, priority high to low:
  1. irq & int_en & !in_isr: IP_sel=011; push ip (the instruction not yet executed); ip<=int_vec; in_isr<=1; int_ack=1 for exactly this cycle.
  2. ret: if sp>0, IP_sel=010, ip<=stack[sp-1], sp<=sp-1, in_isr<=0. If sp==0, IP_sel=000, ip<=ip+4, stack_err<=1.
  3. call: IP_sel=001; ip<=br_target; push ip+4. If sp==DEPTH, the push is dropped, stack_err<=1 and the jump still occurs.
  4. br_taken: IP_sel=001; ip<=br_target.
  5. else: IP_sel=000; ip<=ip+4.
- Interrupt push at sp==DEPTH: the entry is dropped, stack_err<=1 and the interrupt is still taken.
- Simultaneous inputs: the lower-priority request is discarded, not queued. call with ret: ret wins. call with br_taken: treated as call.
- in_isr masks further interrupts; any successful ret clears it (single-level nesting).
- Arithmetic: ip+4 is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0, no flag.
- stack_err is cleared only by reset.
- Reset asserted mid-operation: immediate return to reset values; stack contents are don't-care.
- The encoding 101/110 is never driven.

Test Plan:
- Reset with RESET_VEC=32'h100 -> IP_sel=100 during INIT; then adv=1 for 3 cycles -> ip=0x104, 0x108, 0x10C, IP_sel=000.
- At ip=0x200, call with br_target=0x400 -> ip=0x400, sp=1; two advances, then ret -> IP_sel=010, ip=0x204, sp=0.
- At ip=0x300, irq=1, int_en=1, int_vec=0x80 -> IP_sel=011, int_ack high for 1 cycle, ip=0x80, in_isr=1; irq held high -> no re-entry; ret -> ip=0x300, in_isr=0.
- 9 consecutive calls -> sp saturates at 8, stack_err=1, 9th jump still taken; then 9 rets -> 8 pops, 9th ret gives IP_sel=000 and ip+4.
- adv=0 with br_taken=1 -> IP_sel=111, ip unchanged; same cycle call+ret+br_taken with sp=1 -> ret wins.
- ip=0xFFFF_FFFC, sequential advance -> ip=0x0; reset asserted mid-call sequence -> ip=RESET_VEC and sp=0 asynchronously.
